assoc_lru_cache: RTL and testbench
==================================

ASSOC_LRU_CACHE -- requirements
Module: assoc_lru_cache

Interface
REQ-001 Parameter ADDR_WIDTH, default 8, request address width in bits.
REQ-002 Parameter LINE_SIZE, default 32, line/data width in bits.
REQ-003 Parameter SETS, default 16, number of sets; power of two, at least 2.
REQ-004 Parameter WAYS, default 4, associativity; power of two, at least 2.
REQ-005 Port clk, input, 1 bit: single clock, all logic on its rising edge.
REQ-006 Port rst, input, 1 bit: reset, synchronous and active-low.
REQ-007 Port req_valid, input, 1 bit: request present.
REQ-008 Port req_ready, output, 1 bit: block can accept a request.
REQ-009 Port req_wr, input, 1 bit: 1 for write, 0 for read.
REQ-010 Ports req_addr, input, ADDR_WIDTH, and req_wdata, input, LINE_SIZE: request address and write data.
REQ-011 Ports rsp_valid, output, 1 bit, rsp_hit, output, 1 bit, and rsp_data, output, LINE_SIZE: response strobe, hit flag and read data.
REQ-012 Ports fill_req, output, 1 bit, fill_addr, output, ADDR_WIDTH, fill_ack, input, 1 bit, and fill_data, input, LINE_SIZE: lower-level fill interface.
REQ-013 Ports evict_valid, output, 1 bit, evict_addr, output, ADDR_WIDTH, evict_data, output, LINE_SIZE, and evict_ready, input, 1 bit: dirty-victim migration to the lower level.

Function
REQ-014 Index = req_addr[log2(SETS)-1:0]; tag = the remaining upper address bits; each way holds valid, dirty, tag, data and a log2(WAYS)-bit age.
REQ-015 FSM states: IDLE, LOOKUP, EVICT, FILL, RESP. req_ready = 1 only in IDLE.
REQ-016 A handshake occurs when req_valid and req_ready are both 1; the request is registered and the FSM moves IDLE->LOOKUP.
REQ-017 LOOKUP on hit (valid and tag match): read returns the way's data; write updates data and sets dirty; next state RESP. Hit latency: rsp_valid two cycles after the handshake.
REQ-018 LOOKUP on miss selects the victim: lowest-index invalid way, else the way with age WAYS-1.
REQ-019 If the victim is valid and dirty, the FSM enters EVICT, drives evict_valid=1 with the victim address {tag,index} and its data, and holds until evict_ready=1.
REQ-020 After the victim is handled, a read miss enters FILL: fill_req=1 and fill_addr=req_addr are held until fill_ack=1; fill_data is then installed clean and the FSM moves to RESP.
REQ-021 After the victim is handled, a write miss installs req_wdata as a dirty line without a fill and moves to RESP.
REQ-022 RESP drives rsp_valid=1 for exactly one cycle, with rsp_hit reflecting the LOOKUP result, then returns to IDLE. On a write, rsp_data = 0.
REQ-023 LRU update on every access: the accessed or installed way's age is set to 0; ways in the set with age less than its old age are incremented; other ages are unchanged. Ages stay a permutation of 0..WAYS-1.
REQ-024 Simultaneous evict_ready and fill_ack: the block acts only on the input relevant to the current state; any other input is ignored.

Reset
REQ-025 When rst=0 at a clock edge: all valid and dirty bits are cleared, each way's age is set to its way index, and the FSM goes to IDLE.
REQ-026 During reset, every output is driven to 0 except req_ready, which is 1 in the first cycle after reset deasserts.
REQ-027 Reset during EVICT or FILL abandons the transaction; fill_req and evict_valid are 0 in the cycle after the reset edge.

Configuration
REQ-028 With macro CACHE_STATS_EN defined: 32-bit outputs hit_count and miss_count are present, increment in LOOKUP, wrap at 2^32, and reset to 0.
REQ-029 Without CACHE_STATS_EN: those ports and counters are absent, and all other behaviour is identical.

Verification
REQ-030 After reset, read 0x13 with fill_ack returning 0xDEADBEEF -> rsp_hit=0, rsp_data=0xDEADBEEF; a second read of 0x13 -> rsp_hit=1, rsp_valid two cycles after the handshake.
REQ-031 Write 0x05 with 0xA5A5A5A5, then read 0x05 -> rsp_hit=1, rsp_data=0xA5A5A5A5, fill_req never asserted.
REQ-032 With defaults, write 0x01, 0x11, 0x21 and 0x31, reread 0x01, then write 0x41 -> evict_valid with evict_addr=0x11; hold evict_ready=0 for 5 cycles -> FSM stalls and req_ready=0.
REQ-033 Assert rst=0 during FILL with fill_ack withheld -> fill_req=0 on the next cycle; a subsequent read of the same address misses.
REQ-034 With CACHE_STATS_EN defined, 3 hits and 2 misses -> hit_count=3, miss_count=2; after reset both are 0.

Source files
------------

// File: rtl/assoc_lru_cache.sv
// Set-associative write-back cache with true-LRU ages and a blocking request FSM.
// Define CACHE_STATS_EN to add the 32-bit hit_count / miss_count outputs.
module assoc_lru_cache #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned LINE_SIZE  = 32,
    parameter int unsigned SETS       = 16,
    parameter int unsigned WAYS       = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wr,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [LINE_SIZE-1:0]  req_wdata,
    output logic                  rsp_valid,
    output logic                  rsp_hit,
    output logic [LINE_SIZE-1:0]  rsp_data,
    output logic                  fill_req,
    output logic [ADDR_WIDTH-1:0] fill_addr,
    input  logic                  fill_ack,
    input  logic [LINE_SIZE-1:0]  fill_data,
    output logic                  evict_valid,
    output logic [ADDR_WIDTH-1:0] evict_addr,
    output logic [LINE_SIZE-1:0]  evict_data,
    input  logic                  evict_ready
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]           hit_count,
    output logic [31:0]           miss_count
`endif
);
    localparam int unsigned IDX_W = $clog2(SETS);
    localparam int unsigned TAG_W = ADDR_WIDTH - IDX_W;
    localparam int unsigned AGE_W = $clog2(WAYS);
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(WAYS - 1);

    typedef enum logic [2:0] {IDLE, LOOKUP, EVICT, FILL, RESP} state_t;

    state_t                state_q;
    state_t                next_state;

    logic                  valid_q [SETS][WAYS];
    logic                  dirty_q [SETS][WAYS];
    logic [TAG_W-1:0]      tag_q   [SETS][WAYS];
    logic [LINE_SIZE-1:0]  data_q  [SETS][WAYS];
    logic [AGE_W-1:0]      age_q   [SETS][WAYS];

    logic                  r_wr;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [LINE_SIZE-1:0]  r_wdata;
    logic [AGE_W-1:0]      way_q;
    logic [IDX_W-1:0]      r_idx;
    logic [TAG_W-1:0]      r_tag;

    logic                  hit;
    logic [AGE_W-1:0]      hit_way;
    logic                  found_inv;
    logic [AGE_W-1:0]      victim;
    logic [AGE_W-1:0]      way_sel;
    logic                  touch;
    logic                  wr_line;
    logic                  line_dirty;
    logic [LINE_SIZE-1:0]  line_data;

    logic                  req_ready_d;
    logic                  rsp_valid_d;
    logic                  rsp_hit_d;
    logic [LINE_SIZE-1:0]  rsp_data_d;
    logic                  fill_req_d;
    logic [ADDR_WIDTH-1:0] fill_addr_d;
    logic                  evict_valid_d;
    logic [ADDR_WIDTH-1:0] evict_addr_d;
    logic [LINE_SIZE-1:0]  evict_data_d;

    assign r_idx = r_addr[IDX_W-1:0];
    assign r_tag = r_addr[ADDR_WIDTH-1:IDX_W];

    // Tag match, victim choice, next state and next registered output values
    always_comb begin
        next_state    = state_q;
        hit           = 1'b0;
        hit_way       = '0;
        found_inv     = 1'b0;
        victim        = '0;
        touch         = 1'b0;
        wr_line       = 1'b0;
        line_dirty    = 1'b0;
        line_data     = r_wdata;
        rsp_hit_d     = 1'b0;
        rsp_data_d    = '0;
        fill_addr_d   = '0;
        evict_addr_d  = '0;
        evict_data_d  = '0;

        for (int unsigned w = 0; w < WAYS; w++) begin
            if (valid_q[r_idx][AGE_W'(w)] && (tag_q[r_idx][AGE_W'(w)] == r_tag)) begin
                hit     = 1'b1;
                hit_way = AGE_W'(w);
            end
        end
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (!valid_q[r_idx][AGE_W'(w)] && !found_inv) begin
                found_inv = 1'b1;
                victim    = AGE_W'(w);
            end
        end
        if (!found_inv) begin
            for (int unsigned w = 0; w < WAYS; w++) begin
                if (age_q[r_idx][AGE_W'(w)] == AGE_MAX) victim = AGE_W'(w);
            end
        end
        way_sel = (state_q == LOOKUP) ? (hit ? hit_way : victim) : way_q;

        case (state_q)
            IDLE: begin
                if (req_valid) next_state = LOOKUP;
            end
            LOOKUP: begin
                if (hit) begin
                    touch      = 1'b1;
                    rsp_hit_d  = 1'b1;
                    next_state = RESP;
                    if (r_wr) begin
                        wr_line    = 1'b1;
                        line_dirty = 1'b1;
                    end else begin
                        rsp_data_d = data_q[r_idx][hit_way];
                    end
                end else if (valid_q[r_idx][victim] && dirty_q[r_idx][victim]) begin
                    next_state = EVICT;
                end else if (!r_wr) begin
                    next_state = FILL;
                end else begin
                    touch      = 1'b1;
                    wr_line    = 1'b1;
                    line_dirty = 1'b1;
                    next_state = RESP;
                end
            end
            EVICT: begin
                if (evict_ready) begin
                    if (!r_wr) begin
                        next_state = FILL;
                    end else begin
                        touch      = 1'b1;
                        wr_line    = 1'b1;
                        line_dirty = 1'b1;
                        next_state = RESP;
                    end
                end
            end
            FILL: begin
                if (fill_ack) begin
                    touch      = 1'b1;
                    wr_line    = 1'b1;
                    line_data  = fill_data;
                    rsp_data_d = fill_data;
                    next_state = RESP;
                end
            end
            RESP: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase

        req_ready_d   = (next_state == IDLE);
        rsp_valid_d   = (next_state == RESP);
        fill_req_d    = (next_state == FILL);
        evict_valid_d = (next_state == EVICT);
        if (next_state == EVICT) begin
            evict_addr_d = {tag_q[r_idx][way_sel], r_idx};
            evict_data_d = data_q[r_idx][way_sel];
        end
        if (next_state == FILL) fill_addr_d = r_addr;
    end

    // State, request capture, registered outputs, line status and ages
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            req_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_hit     <= 1'b0;
            rsp_data    <= '0;
            fill_req    <= 1'b0;
            fill_addr   <= '0;
            evict_valid <= 1'b0;
            evict_addr  <= '0;
            evict_data  <= '0;
            r_wr        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            way_q       <= '0;
            for (int unsigned s = 0; s < SETS; s++) begin
                for (int unsigned w = 0; w < WAYS; w++) begin
                    valid_q[IDX_W'(s)][AGE_W'(w)] <= 1'b0;
                    dirty_q[IDX_W'(s)][AGE_W'(w)] <= 1'b0;
                    age_q[IDX_W'(s)][AGE_W'(w)]   <= AGE_W'(w);
                end
            end
        end else begin
            state_q     <= next_state;
            req_ready   <= req_ready_d;
            rsp_valid   <= rsp_valid_d;
            rsp_hit     <= rsp_hit_d;
            rsp_data    <= rsp_data_d;
            fill_req    <= fill_req_d;
            fill_addr   <= fill_addr_d;
            evict_valid <= evict_valid_d;
            evict_addr  <= evict_addr_d;
            evict_data  <= evict_data_d;
            if ((state_q == IDLE) && req_valid) begin
                r_wr    <= req_wr;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
            end
            if (state_q == LOOKUP) way_q <= way_sel;
            if (wr_line) begin
                valid_q[r_idx][way_sel] <= 1'b1;
                dirty_q[r_idx][way_sel] <= line_dirty;
            end
            // Accessed way becomes youngest; only younger ways age by one
            if (touch) begin
                for (int unsigned w = 0; w < WAYS; w++) begin
                    if (AGE_W'(w) == way_sel) begin
                        age_q[r_idx][AGE_W'(w)] <= '0;
                    end else if (age_q[r_idx][AGE_W'(w)] < age_q[r_idx][way_sel]) begin
                        age_q[r_idx][AGE_W'(w)] <= age_q[r_idx][AGE_W'(w)] + AGE_W'(1);
                    end
                end
            end
        end
    end

    // Tag and data storage carry no reset; valid bits qualify them
    always_ff @(posedge clk) begin
        if (wr_line) begin
            tag_q[r_idx][way_sel]  <= r_tag;
            data_q[r_idx][way_sel] <= line_data;
        end
    end

`ifdef CACHE_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (state_q == LOOKUP) begin
            if (hit) hit_count  <= hit_count + 32'd1;
            else     miss_count <= miss_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_assoc_lru_cache.sv
// Randomized self-checking bench for assoc_lru_cache against a recency-list cache model.
module tb_assoc_lru_cache;
    localparam int AW = 8;
    localparam int LW = 32;
    localparam int NS = 16;
    localparam int NW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_wr = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [LW-1:0] req_wdata = '0;
    logic          rsp_valid;
    logic          rsp_hit;
    logic [LW-1:0] rsp_data;
    logic          fill_req;
    logic [AW-1:0] fill_addr;
    logic          fill_ack = 1'b0;
    logic [LW-1:0] fill_data = '0;
    logic          evict_valid;
    logic [AW-1:0] evict_addr;
    logic [LW-1:0] evict_data;
    logic          evict_ready = 1'b0;
`ifdef CACHE_STATS_EN
    logic [31:0]   hit_count;
    logic [31:0]   miss_count;
`endif

    always #5 clk = ~clk;

    assoc_lru_cache #(.ADDR_WIDTH(AW), .LINE_SIZE(LW), .SETS(NS), .WAYS(NW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_data(rsp_data),
        .fill_req(fill_req), .fill_addr(fill_addr), .fill_ack(fill_ack), .fill_data(fill_data),
        .evict_valid(evict_valid), .evict_addr(evict_addr), .evict_data(evict_data),
        .evict_ready(evict_ready)
`ifdef CACHE_STATS_EN
        , .hit_count(hit_count), .miss_count(miss_count)
`endif
    );

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: per-set lines plus a recency list (front = most recent)
    logic        m_valid [NS][NW];
    logic        m_dirty [NS][NW];
    logic [3:0]  m_tag   [NS][NW];
    logic [31:0] m_data  [NS][NW];
    int          m_order [NS][$];
    int          m_hits;
    int          m_misses;

    logic        exp_hit, exp_evict, exp_fill;
    logic [31:0] exp_data, exp_edata;
    logic [7:0]  exp_eaddr, exp_faddr;

    task automatic model_reset();
        for (int s = 0; s < NS; s++) begin
            m_order[s].delete();
            for (int w = 0; w < NW; w++) begin
                m_valid[s][w] = 1'b0;
                m_dirty[s][w] = 1'b0;
                m_order[s].push_back(w);
            end
        end
        m_hits = 0;
        m_misses = 0;
    endtask

    task automatic model_touch(input int s, input int w);
        int pos;
        pos = -1;
        for (int i = 0; i < m_order[s].size(); i++) if (m_order[s][i] == w) pos = i;
        if (pos >= 0) m_order[s].delete(pos);
        m_order[s].push_front(w);
    endtask

    task automatic model_access(input logic wr, input logic [7:0] addr,
                                input logic [31:0] wdata, input logic [31:0] fdata);
        int s;
        int w;
        logic [3:0] t;
        s = int'(addr[3:0]);
        t = addr[7:4];
        w = -1;
        exp_evict = 1'b0;
        exp_fill  = 1'b0;
        exp_faddr = addr;
        exp_eaddr = '0;
        exp_edata = '0;
        for (int i = 0; i < NW; i++) if (m_valid[s][i] && m_tag[s][i] == t) w = i;
        if (w >= 0) begin
            exp_hit = 1'b1;
            m_hits++;
            if (wr) begin
                m_data[s][w]  = wdata;
                m_dirty[s][w] = 1'b1;
                exp_data = '0;
            end else begin
                exp_data = m_data[s][w];
            end
        end else begin
            exp_hit = 1'b0;
            m_misses++;
            for (int i = NW - 1; i >= 0; i--) if (!m_valid[s][i]) w = i;
            if (w < 0) w = m_order[s][m_order[s].size() - 1];
            if (m_valid[s][w] && m_dirty[s][w]) begin
                exp_evict = 1'b1;
                exp_eaddr = {m_tag[s][w], addr[3:0]};
                exp_edata = m_data[s][w];
            end
            m_valid[s][w] = 1'b1;
            m_tag[s][w]   = t;
            if (wr) begin
                m_dirty[s][w] = 1'b1;
                m_data[s][w]  = wdata;
                exp_data = '0;
            end else begin
                exp_fill = 1'b1;
                m_dirty[s][w] = 1'b0;
                m_data[s][w]  = fdata;
                exp_data = fdata;
            end
        end
        model_touch(s, w);
    endtask

    // Per-cycle compare of all outputs against the model's expectations
    logic chk_busy = 1'b0;
    always @(posedge clk) begin
        logic hs;
        logic rs;
        rs = rst;
        hs = rst && req_valid && req_ready;
        #1;
        if (!rs) begin
            chk_busy = 1'b0;
            check("rst_rsp_valid", 32'(rsp_valid), 0);
            check("rst_rsp_data", rsp_data, 0);
            check("rst_fill_req", 32'(fill_req), 0);
            check("rst_evict_valid", 32'(evict_valid), 0);
            check("rst_evict_addr", 32'(evict_addr), 0);
        end else begin
            if (hs) chk_busy = 1'b1;
            check("req_ready", 32'(req_ready), 32'(!chk_busy));
            if (rsp_valid) begin
                check("rsp_in_txn", 32'(chk_busy), 1);
                check("rsp_hit", 32'(rsp_hit), 32'(exp_hit));
                check("rsp_data", rsp_data, exp_data);
                chk_busy = 1'b0;
            end
            if (evict_valid) begin
                check("evict_expected", 32'(exp_evict), 1);
                check("evict_addr", 32'(evict_addr), 32'(exp_eaddr));
                check("evict_data", evict_data, exp_edata);
            end
            if (fill_req) begin
                check("fill_expected", 32'(exp_fill), 1);
                check("fill_addr", 32'(fill_addr), 32'(exp_faddr));
            end
        end
    end

    logic        last_hit;
    logic [31:0] last_data, last_edata;
    logic [7:0]  last_eaddr;
    int          last_lat, ev_cnt, fl_cnt;

    task automatic access(input logic wr, input logic [7:0] addr, input logic [31:0] wdata,
                          input int ev_dly, input int fl_dly, input logic [31:0] fdata);
        int  n;
        bit  done;
        model_access(wr, addr, wdata, fdata);
        ev_cnt = 0;
        fl_cnt = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_wr    = wr;
        req_addr  = addr;
        req_wdata = wdata;
        @(negedge clk);
        req_valid = 1'b0;
        req_wr    = 1'($urandom);
        req_addr  = 8'($urandom);
        req_wdata = $urandom;
        n = 1;
        done = 1'b0;
        while (!done && n < 200) begin
            if (rsp_valid) begin
                last_hit  = rsp_hit;
                last_data = rsp_data;
                last_lat  = n;
                done = 1'b1;
            end else begin
                // Irrelevant handshake inputs are toggled randomly to show they are ignored
                evict_ready = 1'($urandom);
                fill_ack    = 1'($urandom);
                fill_data   = $urandom;
                if (evict_valid) begin
                    ev_cnt++;
                    evict_ready = (ev_cnt > ev_dly);
                    last_eaddr  = evict_addr;
                    last_edata  = evict_data;
                end
                if (fill_req) begin
                    fl_cnt++;
                    fill_ack  = (fl_cnt > fl_dly);
                    fill_data = fdata;
                end
                @(negedge clk);
                n++;
            end
        end
        evict_ready = 1'b0;
        fill_ack    = 1'b0;
        if (!done) check("rsp_timeout", 0, 1);
        check("evict_cycles", ev_cnt, exp_evict ? ev_dly + 1 : 0);
        check("fill_cycles", fl_cnt, exp_fill ? fl_dly + 1 : 0);
        if (exp_hit) check("hit_latency", n, 2);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("post_reset_ready", 32'(req_ready), 1);

        // Read miss with fill, then read hit
        access(1'b0, 8'h13, 32'h0, 0, 2, 32'hDEADBEEF);
        check("r13_miss_hit", 32'(last_hit), 0);
        check("r13_miss_data", last_data, 32'hDEADBEEF);
        access(1'b0, 8'h13, 32'h0, 0, 0, 32'h0);
        check("r13_hit", 32'(last_hit), 1);
        check("r13_hit_lat", last_lat, 2);
        check("r13_hit_data", last_data, 32'hDEADBEEF);

        // Write-allocate without fill, then read back
        access(1'b1, 8'h05, 32'hA5A5A5A5, 0, 0, 32'h0);
        check("w05_data_zero", last_data, 0);
        check("w05_no_fill", fl_cnt, 0);
        access(1'b0, 8'h05, 32'h0, 0, 0, 32'h0);
        check("r05_hit", 32'(last_hit), 1);
        check("r05_data", last_data, 32'hA5A5A5A5);
        check("r05_no_fill", fl_cnt, 0);

        // Fill set 1, refresh way holding 0x01, then the LRU line 0x11 is evicted
        access(1'b1, 8'h01, 32'h1000_0001, 0, 0, 32'h0);
        access(1'b1, 8'h11, 32'h1000_0011, 0, 0, 32'h0);
        access(1'b1, 8'h21, 32'h1000_0021, 0, 0, 32'h0);
        access(1'b1, 8'h31, 32'h1000_0031, 0, 0, 32'h0);
        access(1'b0, 8'h01, 32'h0, 0, 0, 32'h0);
        check("r01_hit", 32'(last_hit), 1);
        access(1'b1, 8'h41, 32'h1000_0041, 5, 0, 32'h0);
        check("w41_evict_addr", 32'(last_eaddr), 32'h11);
        check("w41_evict_data", last_edata, 32'h1000_0011);
        check("w41_evict_stall", ev_cnt, 6);
        check("w41_miss", 32'(last_hit), 0);

        // Reset while a fill is outstanding
        model_access(1'b0, 8'h77, 32'h0, 32'h0);
        @(negedge clk);
        req_valid = 1'b1;
        req_wr    = 1'b0;
        req_addr  = 8'h77;
        @(negedge clk);
        req_valid = 1'b0;
        for (int i = 0; i < 10 && !fill_req; i++) @(negedge clk);
        check("abort_fill_seen", 32'(fill_req), 1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("abort_fill_req", 32'(fill_req), 0);
        check("abort_evict_valid", 32'(evict_valid), 0);
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        check("abort_ready", 32'(req_ready), 1);
`ifdef CACHE_STATS_EN
        check("stats_rst_hits", hit_count, 0);
        check("stats_rst_misses", miss_count, 0);
`endif
        access(1'b0, 8'h77, 32'h0, 0, 1, 32'h0000_7777);
        check("r77_after_reset_miss", 32'(last_hit), 0);
        access(1'b0, 8'h13, 32'h0, 0, 0, 32'h1313_1313);
        check("r13_after_reset_miss", 32'(last_hit), 0);
        check("r13_after_reset_data", last_data, 32'h1313_1313);

        // Randomized traffic concentrated on a few sets to force conflicts
        for (int i = 0; i < 300; i++) begin
            logic [7:0] a;
            a = {4'($urandom), 4'($urandom_range(0, 2))};
            access(1'($urandom), a, $urandom, int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 3)), $urandom);
        end
`ifdef CACHE_STATS_EN
        @(negedge clk);
        check("stats_hits", hit_count, 32'(m_hits));
        check("stats_misses", miss_count, 32'(m_misses));
`endif
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
